bless_xbar_stage: RTL and testbench

//  Crossbar traversal stage of the age-based bufferless (BLESS) router, directly downstream of the
//  5-lane flit pipeline register. Steers the 5 registered input flits (lanes 0-3 network, lane 4

---
 rtl/bless_xbar_stage.sv | 151 +++++++++++++++
 tb/tb_bless_xbar_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bless_xbar_stage.sv
// Crossbar traversal stage of the BLESS router: steers 5 lanes onto 5 ports, ages link flits and
// registers the result. Define BLESS_XBAR_STATS_EN to add the flit/deflection counters.
module bless_xbar_stage #(
  parameter int DATA_W    = 128,
  parameter int VALID_BIT = 127,
  parameter int AGE_LSB   = 8,
  parameter int AGE_W     = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data0_in,
  input  logic [DATA_W-1:0] data1_in,
  input  logic [DATA_W-1:0] data2_in,
  input  logic [DATA_W-1:0] data3_in,
  input  logic [DATA_W-1:0] data4_in,
  input  logic [2:0]        sel0,
  input  logic [2:0]        sel1,
  input  logic [2:0]        sel2,
  input  logic [2:0]        sel3,
  input  logic [2:0]        sel4,
  input  logic [4:0]        defl_in,
  output logic [DATA_W-1:0] data0_out,
  output logic [DATA_W-1:0] data1_out,
  output logic [DATA_W-1:0] data2_out,
  output logic [DATA_W-1:0] data3_out,
  output logic [DATA_W-1:0] data4_out,
  output logic [4:0]        out_vld,
  output logic              dup_err,
  output logic              drop_err
`ifdef BLESS_XBAR_STATS_EN
  ,
  output logic [CNT_W-1:0]  flit_cnt,
  output logic [CNT_W-1:0]  defl_cnt
`endif
);

  localparam int N = 5;

  logic [DATA_W-1:0] din    [N];
  logic [2:0]        sel    [N];
  logic [DATA_W-1:0] dout_d [N];
  logic [DATA_W-1:0] dout_q [N];
  logic [N-1:0]      claimed;
  logic              dup_d;
  logic              drop_d;

  assign din[0] = data0_in;
  assign din[1] = data1_in;
  assign din[2] = data2_in;
  assign din[3] = data3_in;
  assign din[4] = data4_in;
  assign sel[0] = sel0;
  assign sel[1] = sel1;
  assign sel[2] = sel2;
  assign sel[3] = sel3;
  assign sel[4] = sel4;

  // Saturating increment of the age field; every other bit passes untouched.
  function automatic logic [DATA_W-1:0] age_bump(input logic [DATA_W-1:0] f);
    logic [DATA_W-1:0] r;
    r = f;
    if (f[AGE_LSB +: AGE_W] != {AGE_W{1'b1}})
      r[AGE_LSB +: AGE_W] = f[AGE_LSB +: AGE_W] + AGE_W'(1);
    return r;
  endfunction

  // Ports are scanned in ascending order so the lowest-numbered port claims a contested lane.
  always_comb begin
    // NOTE: every variable gets a default before the loops, otherwise unassigned paths infer latches.
    claimed = '0;
    dup_d   = 1'b0;
    drop_d  = 1'b0;
    for (int p = 0; p < N; p++) begin
      dout_d[p] = '0;
      for (int l = 0; l < N; l++) begin
        if (sel[p] == 3'(l) && din[l][VALID_BIT]) begin
          if (claimed[l]) begin
            dup_d = 1'b1;
          end else begin
            claimed[l] = 1'b1;
            dout_d[p]  = (p < N - 1) ? age_bump(din[l]) : din[l];
          end
        end
      end
    end
    for (int l = 0; l < N; l++)
      if (din[l][VALID_BIT] && !claimed[l]) drop_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset lives inside the clocked branch; the flit in flight is discarded.
    if (!rst_n) begin
      for (int p = 0; p < N; p++) dout_q[p] <= '0;
      dup_err  <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      for (int p = 0; p < N; p++) dout_q[p] <= dout_d[p];
      dup_err  <= dup_err | dup_d;
      drop_err <= drop_err | drop_d;
    end
  end

  assign data0_out = dout_q[0];
  assign data1_out = dout_q[1];
  assign data2_out = dout_q[2];
  assign data3_out = dout_q[3];
  assign data4_out = dout_q[4];

  always_comb begin
    out_vld = '0;
    for (int p = 0; p < N; p++) out_vld[p] = dout_q[p][VALID_BIT];
  end

`ifdef BLESS_XBAR_STATS_EN
  logic [2:0]     flit_inc;
  logic [2:0]     defl_inc;
  logic [CNT_W:0] flit_sum;
  logic [CNT_W:0] defl_sum;

  // A valid link-port result always came from the lane that port selected.
  always_comb begin
    flit_inc = '0;
    defl_inc = '0;
    for (int p = 0; p < N - 1; p++) begin
      if (dout_d[p][VALID_BIT]) begin
        flit_inc = flit_inc + 3'd1;
        for (int l = 0; l < N; l++)
          if (sel[p] == 3'(l) && defl_in[l]) defl_inc = defl_inc + 3'd1;
      end
    end
  end

  assign flit_sum = {1'b0, flit_cnt} + (CNT_W + 1)'(flit_inc);
  assign defl_sum = {1'b0, defl_cnt} + (CNT_W + 1)'(defl_inc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flit_cnt <= '0;
      defl_cnt <= '0;
    end else begin
      flit_cnt <= flit_sum[CNT_W] ? {CNT_W{1'b1}} : flit_sum[CNT_W-1:0];
      defl_cnt <= defl_sum[CNT_W] ? {CNT_W{1'b1}} : defl_sum[CNT_W-1:0];
    end
  end
`else
  logic [CNT_W-1:0] unused_stats;
  assign unused_stats = CNT_W'(defl_in);
`endif

endmodule

// File: tb/tb_bless_xbar_stage.sv
// Scoreboard bench for bless_xbar_stage: a reference model pushes expected port contents per driven
// cycle, and they are popped and compared one cycle later on the falling edge.
module tb_bless_xbar_stage;

  typedef struct packed {
    logic [4:0][127:0] d;
    logic              dup;
    logic              drop;
    logic [15:0]       fc;
    logic [15:0]       dc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] data0_in = '0, data1_in = '0, data2_in = '0, data3_in = '0, data4_in = '0;
  logic [2:0]   sel0 = 3'd7, sel1 = 3'd7, sel2 = 3'd7, sel3 = 3'd7, sel4 = 3'd7;
  logic [4:0]   defl_in = '0;
  logic [127:0] data0_out, data1_out, data2_out, data3_out, data4_out;
  logic [4:0]   out_vld;
  logic         dup_err, drop_err;
`ifdef BLESS_XBAR_STATS_EN
  logic [15:0]  flit_cnt, defl_cnt;
`endif

  bless_xbar_stage dut (
    .clk(clk), .rst_n(rst_n),
    .data0_in(data0_in), .data1_in(data1_in), .data2_in(data2_in),
    .data3_in(data3_in), .data4_in(data4_in),
    .sel0(sel0), .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4),
    .defl_in(defl_in),
    .data0_out(data0_out), .data1_out(data1_out), .data2_out(data2_out),
    .data3_out(data3_out), .data4_out(data4_out),
    .out_vld(out_vld), .dup_err(dup_err), .drop_err(drop_err)
`ifdef BLESS_XBAR_STATS_EN
    , .flit_cnt(flit_cnt), .defl_cnt(defl_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic m_dup = 1'b0, m_drop = 1'b0;
  logic [15:0] m_fc = '0, m_dc = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check("port0", data0_out, e.d[0]);
    check("port1", data1_out, e.d[1]);
    check("port2", data2_out, e.d[2]);
    check("port3", data3_out, e.d[3]);
    check("port4", data4_out, e.d[4]);
    check("out_vld", 128'(out_vld),
          128'({e.d[4][127], e.d[3][127], e.d[2][127], e.d[1][127], e.d[0][127]}));
    check("dup_err", 128'(dup_err), 128'(e.dup));
    check("drop_err", 128'(drop_err), 128'(e.drop));
`ifdef BLESS_XBAR_STATS_EN
    check("flit_cnt", 128'(flit_cnt), 128'(e.fc));
    check("defl_cnt", 128'(defl_cnt), 128'(e.dc));
`endif
  endtask

  function automatic logic [127:0] mk(input logic v, input logic [7:0] age);
    logic [127:0] f;
    f = {$urandom, $urandom, $urandom, $urandom};
    f[127] = v;
    f[15:8] = age;
    return f;
  endfunction

  function automatic logic [127:0] aged(input logic [127:0] f);
    logic [127:0] r;
    r = f;
    r[15:8] = (f[15:8] == 8'hFF) ? 8'hFF : f[15:8] + 8'd1;
    return r;
  endfunction

  // One cycle: check what the previous cycle produced, then drive new inputs and predict them.
  task automatic step(input logic [4:0][127:0] fl, input logic [4:0][2:0] s,
                      input logic [4:0] dfl, input logic rst);
    exp_t e;
    logic [4:0] used;
    int l;
    @(negedge clk);
    compare_front();
    rst_n = rst;
    data0_in = fl[0]; data1_in = fl[1]; data2_in = fl[2]; data3_in = fl[3]; data4_in = fl[4];
    sel0 = s[0]; sel1 = s[1]; sel2 = s[2]; sel3 = s[3]; sel4 = s[4];
    defl_in = dfl;
    e = '0;
    if (!rst) begin
      m_dup = 1'b0; m_drop = 1'b0; m_fc = '0; m_dc = '0;
    end else begin
      used = '0;
      for (int p = 0; p < 5; p++) begin
        if (s[p] <= 3'd4) begin
          l = int'(s[p]);
          if (fl[l][127]) begin
            if (used[l]) m_dup = 1'b1;
            else begin
              used[l] = 1'b1;
              if (p == 4) e.d[p] = fl[l];
              else begin
                e.d[p] = aged(fl[l]);
                if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
                if (dfl[l] && m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
              end
            end
          end
        end
      end
      for (int k = 0; k < 5; k++) if (fl[k][127] && !used[k]) m_drop = 1'b1;
    end
    e.dup = m_dup; e.drop = m_drop; e.fc = m_fc; e.dc = m_dc;
    sb_q.push_back(e);
  endtask

  logic [4:0][127:0] fl;
  logic [4:0][2:0]   s;
  logic [4:0][2:0]   straight;
  logic [4:0][2:0]   idle;

  initial begin
    for (int p = 0; p < 5; p++) begin
      straight[p] = 3'(p);
      idle[p] = 3'd7;
    end

    // Reset while valid flits are presented straight through
    for (int l = 0; l < 5; l++) fl[l] = mk(1'b1, 8'd3);
    step(fl, straight, 5'b0, 1'b0);
    step(fl, straight, 5'b0, 1'b0);

    // Straight traversal, age 3
    for (int i = 0; i < 3; i++) begin
      for (int l = 0; l < 5; l++) fl[l] = mk(1'b1, 8'd3);
      step(fl, straight, 5'b0, 1'b1);
    end

    // Age saturation
    fl = '0;
    fl[2] = mk(1'b1, 8'hFF);
    fl[0] = mk(1'b1, 8'hFE);
    s = idle; s[1] = 3'd2; s[0] = 3'd0;
    step(fl, s, 5'b0, 1'b1);

    // Duplicate grant, then clean traffic keeps dup_err sticky until reset
    fl = '0;
    fl[3] = mk(1'b1, 8'd5);
    s = idle; s[0] = 3'd3; s[2] = 3'd3;
    step(fl, s, 5'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      for (int l = 0; l < 5; l++) fl[l] = mk(1'b1, 8'(i));
      step(fl, straight, 5'b0, 1'b1);
    end
    step(fl, straight, 5'b0, 1'b0);

    // Drop, then invalid unselected lanes raise nothing
    fl = '0;
    fl[0] = mk(1'b1, 8'd1);
    fl[1] = mk(1'b1, 8'd1);
    s = idle; s[0] = 3'd0;
    step(fl, s, 5'b0, 1'b1);
    step('0, idle, 5'b0, 1'b0);
    for (int l = 0; l < 5; l++) fl[l] = mk(1'b0, 8'd9);
    step(fl, idle, 5'b0, 1'b1);
    step(fl, idle, 5'b0, 1'b1);

    // Random permutations of all-valid lanes: no errors expected
    for (int i = 0; i < 20; i++) begin
      s = straight;
      for (int k = 4; k > 0; k--) begin
        int j;
        logic [2:0] t;
        j = $urandom_range(0, k);
        t = s[k]; s[k] = s[j]; s[j] = t;
      end
      for (int l = 0; l < 5; l++) fl[l] = mk(1'b1, ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      step(fl, s, 5'($urandom), 1'b1);
    end

    // Fully random traffic including idle/invalid selects and conflicts
    for (int i = 0; i < 30; i++) begin
      for (int l = 0; l < 5; l++) fl[l] = mk(1'($urandom), 8'($urandom));
      for (int p = 0; p < 5; p++) s[p] = 3'($urandom_range(0, 7));
      step(fl, s, 5'($urandom), 1'b1);
    end

`ifdef BLESS_XBAR_STATS_EN
    // 10 cycles of 4 link flits with lanes 0,1 deflected -> 40 / 20
    step('0, idle, 5'b0, 1'b0);
    s = idle; s[0] = 3'd0; s[1] = 3'd1; s[2] = 3'd2; s[3] = 3'd3;
    for (int i = 0; i < 10; i++) begin
      fl = '0;
      for (int l = 0; l < 4; l++) fl[l] = mk(1'b1, 8'd2);
      step(fl, s, 5'b00011, 1'b1);
    end
    @(negedge clk);
    compare_front();
    check("flit_cnt_40", 128'(flit_cnt), 128'd40);
    check("defl_cnt_20", 128'(defl_cnt), 128'd20);
    // Run both counters into saturation
    for (int i = 0; i < 16400; i++) begin
      fl = '0;
      for (int l = 0; l < 4; l++) fl[l] = mk(1'b1, 8'd2);
      step(fl, s, 5'b01111, 1'b1);
    end
    @(negedge clk);
    compare_front();
    check("flit_cnt_sat", 128'(flit_cnt), 128'hFFFF);
`endif

    step('0, idle, 5'b0, 1'b1);
    @(negedge clk);
    compare_front();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
